// File: rtl/esti_pkg.sv
// Shared types, defaults and the saturating adder for the
// acceleration-to-position integrator.
package esti_pkg;

   typedef enum logic [1:0] {
      ZS_IDLE,
      ZS_SCAN,
      ZS_DONE
   } zone_state_t;

   typedef enum logic {
      MODE_CAL,
      MODE_RUN
   } mode_t;

   localparam logic [63:0] ZONE_STEP_DEFAULT = 64'h0000_0000_C26D_D3E6;

   // Operands are sign-extended to this width so the raw sum can never wrap.
   localparam int unsigned SAT_W = 128;

   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [SAT_W-1:0] b,
      input int unsigned             w
   );
      logic        [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] s;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      one = SAT_W'(1);
      hi  = $signed((one << (w - 1)) - one);
      lo  = ~hi;
      s   = a + b;
      if (s > hi)
         sat_add = hi;
      else if (s < lo)
         sat_add = lo;
      else
         sat_add = s;
   endfunction

endpackage

// File: rtl/esti_axis_acc.sv
// One axis: calibration sum, bias, and saturating velocity/position
// accumulators.
module esti_axis_acc
   import esti_pkg::*;
#(
   parameter int unsigned ACC_W    = 16,
   parameter int unsigned POS_W    = 64,
   parameter int unsigned CAL_LOG2 = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ACC_W-1:0] acc,
   input  logic             cal_en,
   input  logic             cal_last,
   input  logic             run_en,
   input  logic             clr,
   output logic [POS_W-1:0] pos
);

   localparam int unsigned SUM_W = ACC_W + CAL_LOG2;

   logic signed [SUM_W-1:0] sum_q;
   logic signed [SUM_W-1:0] sum_n;
   logic signed [ACC_W-1:0] bias_q;
   logic signed [POS_W-1:0] vel_q;
   logic signed [POS_W-1:0] pos_q;
   logic signed [POS_W-1:0] vel_n;
   logic signed [POS_W-1:0] pos_n;
   logic signed [SAT_W-1:0] acc_w;
   logic signed [SAT_W-1:0] bias_w;
   logic signed [SAT_W-1:0] vel_s;

   always_comb begin
      sum_n  = sum_q + SUM_W'($signed(acc));
      acc_w  = SAT_W'($signed(acc));
      bias_w = SAT_W'(bias_q);
      // pos integrates the already-updated velocity of this same sample
      vel_s  = sat_add(SAT_W'(vel_q), acc_w - bias_w, POS_W);
      vel_n  = POS_W'(vel_s);
      pos_n  = POS_W'(sat_add(SAT_W'(pos_q), vel_s, POS_W));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q  <= '0;
         bias_q <= '0;
         vel_q  <= '0;
         pos_q  <= '0;
      end else begin
         if (cal_en) begin
            sum_q <= sum_n;
            if (cal_last)
               bias_q <= ACC_W'(sum_n >>> CAL_LOG2);
         end
         if (clr) begin
            vel_q <= '0;
            pos_q <= '0;
         end else if (run_en) begin
            vel_q <= vel_n;
            pos_q <= pos_n;
         end
      end
   end

   assign pos = pos_q;

endmodule

// File: rtl/esti_axis_integrator.sv
// Multi-axis accelerometer integrator: bias calibration, per-axis
// velocity/position integration and an LED zone display of one axis.
module esti_axis_integrator
   import esti_pkg::*;
#(
   parameter int unsigned NUM_AXES  = 3,
   parameter int unsigned ACC_W     = 16,
   parameter int unsigned POS_W     = 64,
   parameter int unsigned NUM_LEDS  = 8,
   parameter logic [63:0] ZONE_STEP = ZONE_STEP_DEFAULT,
   parameter int unsigned CAL_LOG2  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample_valid,
   input  logic [NUM_AXES*ACC_W-1:0] rx_bytes,
   input  logic [1:0]                axis_sel,
   input  logic                      zero_req,
   output logic [NUM_LEDS-1:0]       led_out,
   output logic [POS_W-1:0]          pos_out,
   output logic                      cal_done,
   output logic                      busy
);

   localparam int unsigned CNT_W = CAL_LOG2 + 1;
   localparam int unsigned TH_W  = ((POS_W > 64) ? POS_W : 64) + 8;
   localparam int unsigned IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [CNT_W-1:0]       CAL_LAST = CNT_W'(2**CAL_LOG2 - 1);
   localparam logic [IDX_W-1:0]       K_LAST   = IDX_W'(NUM_LEDS - 1);
   localparam logic signed [TH_W-1:0] STEP_W   = TH_W'(ZONE_STEP);

   function automatic logic [NUM_LEDS-1:0] oor_pattern();
      logic [NUM_LEDS-1:0] p;
      for (int unsigned i = 0; i < NUM_LEDS; i++)
         p[i] = (i % 2 == 0);
      return p;
   endfunction

   localparam logic [NUM_LEDS-1:0] OOR_PAT = oor_pattern();

   mode_t                   mode_q;
   logic [CNT_W-1:0]        cal_cnt_q;
   logic                    in_run;
   logic                    cal_en;
   logic                    cal_last;
   logic                    run_en;
   logic                    clr;
   logic [1:0]              sel;
   logic [POS_W-1:0]        pos_arr [NUM_AXES];

   zone_state_t             st_q;
   zone_state_t             st_n;
   logic                    trig_q;
   logic [1:0]              axis_sel_q;
   logic signed [POS_W-1:0] scan_pos_q;
   logic signed [TH_W-1:0]  thresh_q;
   logic [IDX_W-1:0]        k_q;
   logic [NUM_LEDS-1:0]     led_q;
   logic [NUM_LEDS-1:0]     led_n;
   logic                    scan_ld;
   logic                    scan_step;

   assign in_run   = (mode_q == MODE_RUN);
   assign cal_en   = !in_run && sample_valid;
   assign cal_last = cal_en && (cal_cnt_q == CAL_LAST);
   assign run_en   = in_run && sample_valid && !zero_req;
   assign clr      = in_run && zero_req;

   for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
      esti_axis_acc #(
         .ACC_W    (ACC_W),
         .POS_W    (POS_W),
         .CAL_LOG2 (CAL_LOG2)
      ) u_acc (
         .clk      (clk),
         .reset    (reset),
         .acc      (rx_bytes[ACC_W*g +: ACC_W]),
         .cal_en   (cal_en),
         .cal_last (cal_last),
         .run_en   (run_en),
         .clr      (clr),
         .pos      (pos_arr[g])
      );
   end

   assign sel      = (32'(axis_sel) < NUM_AXES) ? axis_sel : 2'd0;
   assign pos_out  = pos_arr[sel];
   assign cal_done = in_run;
   assign busy     = (st_q != ZS_IDLE);
   assign led_out  = led_q;

   always_ff @(posedge clk) begin
      if (reset)
         st_q <= ZS_IDLE;
      else
         st_q <= st_n;
   end

   // A pending trigger always wins, so a stale scan never reaches DONE.
   always_comb begin
      st_n      = st_q;
      led_n     = led_q;
      scan_ld   = 1'b0;
      scan_step = 1'b0;
      case (st_q)
         ZS_IDLE: begin
            if (trig_q) begin
               st_n    = ZS_SCAN;
               scan_ld = 1'b1;
            end
         end
         ZS_SCAN: begin
            if (trig_q) begin
               scan_ld = 1'b1;
            end else begin
               st_n = ZS_DONE;
               if (scan_pos_q[POS_W-1])
                  led_n = OOR_PAT;
               else if (TH_W'(scan_pos_q) < thresh_q)
                  led_n = NUM_LEDS'(1) << k_q;
               else if (k_q == K_LAST)
                  led_n = OOR_PAT;
               else begin
                  st_n      = ZS_SCAN;
                  scan_step = 1'b1;
               end
            end
         end
         ZS_DONE: begin
            if (trig_q) begin
               st_n    = ZS_SCAN;
               scan_ld = 1'b1;
            end else begin
               st_n = ZS_IDLE;
            end
         end
         default: st_n = ZS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= MODE_CAL;
         cal_cnt_q  <= '0;
         trig_q     <= 1'b0;
         axis_sel_q <= '0;
         scan_pos_q <= '0;
         thresh_q   <= '0;
         k_q        <= '0;
         led_q      <= '0;
      end else begin
         if (cal_en)
            cal_cnt_q <= cal_cnt_q + CNT_W'(1);
         if (cal_last)
            mode_q <= MODE_RUN;
         trig_q     <= in_run && (run_en || clr || (axis_sel != axis_sel_q));
         axis_sel_q <= axis_sel;
         led_q      <= led_n;
         if (scan_ld) begin
            scan_pos_q <= pos_out;
            thresh_q   <= STEP_W;
            k_q        <= '0;
         end else if (scan_step) begin
            thresh_q <= thresh_q + STEP_W;
            k_q      <= k_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_esti_axis_integrator.sv
// Directed bench for esti_axis_integrator: calibration, integration,
// zone display, zeroing, saturation and scan restart/abort.
module tb_esti_axis_integrator;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [47:0] rx_bytes;
   logic [1:0]  axis_sel;
   logic        zero_req;
   logic [7:0]  led_out;
   logic [63:0] pos_out;
   logic        cal_done;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic signed [63:0] m_vel;
   logic signed [63:0] m_pos;

   localparam logic [63:0] PMAX = 64'h7FFF_FFFF_FFFF_FFFF;

   esti_axis_integrator dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .rx_bytes     (rx_bytes),
      .axis_sel     (axis_sel),
      .zero_req     (zero_req),
      .led_out      (led_out),
      .pos_out      (pos_out),
      .cal_done     (cal_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One accepted sample on all axes; model assumes calibrated bias of 100.
   task automatic send(input logic [15:0] a);
      rx_bytes     = {3{a}};
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      m_vel = m_vel + 64'($signed(a)) - 64'sd100;
      m_pos = m_pos + m_vel;
   endtask

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      rx_bytes     = '0;
      axis_sel     = 2'd0;
      zero_req     = 1'b0;
      m_vel        = '0;
      m_pos        = '0;
      @(negedge clk);
      tick();
      tick();
      chk("rst_led", 64'(led_out), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_cal_done", 64'(cal_done), 64'h0);
      chk("rst_pos", pos_out, 64'h0);
      reset = 1'b0;

      // calibration
      for (int i = 0; i < 15; i++) send(16'd100);
      chk("cal_not_done_15", 64'(cal_done), 64'h0);
      send(16'd100);
      chk("cal_done_16", 64'(cal_done), 64'h1);
      chk("bias0", 64'(dut.g_axis[0].u_acc.bias_q), 64'd100);
      chk("bias1", 64'(dut.g_axis[1].u_acc.bias_q), 64'd100);
      chk("bias2", 64'(dut.g_axis[2].u_acc.bias_q), 64'd100);
      chk("cal_led", 64'(led_out), 64'h0);
      chk("cal_pos", pos_out, 64'h0);

      // first integration step and scan timing
      send(16'd110);
      chk("vel_first", 64'(dut.g_axis[0].u_acc.vel_q), 64'd10);
      chk("pos_first", pos_out, 64'd10);
      chk("busy_idle_trig", 64'(busy), 64'h0);
      tick();
      chk("busy_scan", 64'(busy), 64'h1);
      chk("led_hold_scan", 64'(led_out), 64'h0);
      tick();
      chk("led_zone0", 64'(led_out), 64'h01);
      tick();
      chk("busy_back_idle", 64'(busy), 64'h0);

      zero_req = 1'b1;
      tick();
      zero_req = 1'b0;
      m_vel = '0;
      m_pos = '0;
      chk("zero_pos", pos_out, 64'h0);
      repeat (3) tick();

      // 632 samples of d=32667 lands in zone 2, 1263 in zone 7
      for (int i = 0; i < 632; i++) send(16'h7FFF);
      repeat (12) tick();
      chk("pos_632", pos_out, 64'(m_pos));
      chk("led_zone2", 64'(led_out), 64'h04);
      for (int i = 0; i < 631; i++) send(16'h7FFF);
      repeat (12) tick();
      chk("pos_1263", pos_out, 64'(m_pos));
      chk("led_zone7", 64'(led_out), 64'h80);

      // restart: scan of zone-7 pos interrupted by a sample pushing past 8 zones
      axis_sel = 2'd1;
      tick();
      tick();
      tick();
      chk("busy_mid_scan", 64'(busy), 64'h1);
      send(16'd100);
      repeat (8) tick();
      chk("led_held_restart", 64'(led_out), 64'h80);
      chk("busy_restart", 64'(busy), 64'h1);
      tick();
      chk("led_over_range", 64'(led_out), 64'h55);
      tick();
      chk("busy_after_done", 64'(busy), 64'h0);
      chk("pos_axis1", pos_out, 64'(m_pos));

      axis_sel = 2'd3;
      tick();
      chk("pos_sel3_axis0", pos_out, 64'(m_pos));
      axis_sel = 2'd0;
      repeat (13) tick();
      chk("led_sel0_over", 64'(led_out), 64'h55);

      // zero with simultaneous sample
      zero_req     = 1'b1;
      sample_valid = 1'b1;
      rx_bytes     = {3{16'h7FFF}};
      tick();
      zero_req     = 1'b0;
      sample_valid = 1'b0;
      m_vel = '0;
      m_pos = '0;
      chk("zs_pos", pos_out, 64'h0);
      chk("zs_vel", 64'(dut.g_axis[0].u_acc.vel_q), 64'h0);
      chk("zs_bias", 64'(dut.g_axis[0].u_acc.bias_q), 64'd100);
      repeat (3) tick();
      chk("zs_led", 64'(led_out), 64'h01);
      chk("zs_busy", 64'(busy), 64'h0);

      // negative position
      send(16'd99);
      chk("neg_pos", pos_out, 64'hFFFF_FFFF_FFFF_FFFF);
      repeat (3) tick();
      chk("neg_led", 64'(led_out), 64'h55);

      // saturation on axis 0
      force dut.g_axis[0].u_acc.vel_q = 64'h7FFF_FFFF_FFFF_FFFA;
      force dut.g_axis[0].u_acc.pos_q = 64'h7FFF_FFFF_FFFF_FF00;
      #1;
      release dut.g_axis[0].u_acc.vel_q;
      release dut.g_axis[0].u_acc.pos_q;
      send(16'd110);
      chk("sat_vel", 64'(dut.g_axis[0].u_acc.vel_q), PMAX);
      chk("sat_pos", pos_out, PMAX);
      send(16'h7FFF);
      chk("sat_pos_hold", pos_out, PMAX);
      send(16'd100);
      chk("sat_no_flip", pos_out, PMAX);

      // axis 1 pos = 65360 (zone 0), then abort an 8-step scan of axis 0
      axis_sel = 2'd1;
      repeat (4) tick();
      chk("axis1_pos", pos_out, 64'd65360);
      chk("axis1_led", 64'(led_out), 64'h01);
      axis_sel = 2'd0;
      tick();
      tick();
      tick();
      chk("abort_busy_pre", 64'(busy), 64'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_led", 64'(led_out), 64'h0);
      chk("abort_busy", 64'(busy), 64'h0);
      chk("abort_pos", pos_out, 64'h0);
      chk("abort_cal_done", 64'(cal_done), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
